overlay_mixer: RTL

Priority compositor between the overlay generators (the state-symbol overlay, the song-title text layer, the progress-bar layer) and the VGA output stage. Takes three overlay layers, each a 24-bit colour plus `valid_px`, and merges them over a fixed background colour in a 2-stage registered pipeline. Also provides frame-synchronous blinking for any layer, so the CHANGE-state symbol can flash without per-layer counters. Forwards delayed pixel coordinates so downstream logic stays aligned.

---
 rtl/overlay_mixer_if.sv | 42 ++++
 rtl/overlay_mixer.sv | 117 +++++++++++
 2 files changed

// File: rtl/overlay_mixer_if.sv
// overlay_mixer_if: pixel-stream bundle between the overlay generators,
// the mixer and the VGA output stage.
//   master : drives the timing/coordinates, the three layers and blink_en;
//            receives the composited pixel, delayed coordinates and phase.
//   slave  : the mixer side (mirror of master).
interface overlay_mixer_if;
  // input side: timing, coordinates, layers, blink enables
  logic        valid;
  logic [10:0] vga_x;
  logic [9:0]  vga_y;
  logic [7:0]  l0_r, l0_g, l0_b;
  logic        l0_valid_px;
  logic [7:0]  l1_r, l1_g, l1_b;
  logic        l1_valid_px;
  logic [7:0]  l2_r, l2_g, l2_b;
  logic        l2_valid_px;
  logic [2:0]  blink_en;
  // output side: composited pixel, aligned coordinates, blink phase
  logic [7:0]  r, g, b;
  logic        valid_out;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        blink_phase;

  modport master (
    output valid, vga_x, vga_y,
           l0_r, l0_g, l0_b, l0_valid_px,
           l1_r, l1_g, l1_b, l1_valid_px,
           l2_r, l2_g, l2_b, l2_valid_px,
           blink_en,
    input  r, g, b, valid_out, out_x, out_y, blink_phase
  );

  modport slave (
    input  valid, vga_x, vga_y,
           l0_r, l0_g, l0_b, l0_valid_px,
           l1_r, l1_g, l1_b, l1_valid_px,
           l2_r, l2_g, l2_b, l2_valid_px,
           blink_en,
    output r, g, b, valid_out, out_x, out_y, blink_phase
  );
endinterface

// File: rtl/overlay_mixer.sv
// overlay_mixer: priority compositor of three overlay layers over a fixed
// background, 2-stage registered pipeline, with frame-synchronous blinking.
//   clk   : pixel clock
//   reset : asynchronous, active-low
//   pix   : overlay_mixer_if.slave -- inputs valid/vga_x/vga_y, layers
//           l0..l2 (l0 highest priority), blink_en; outputs r/g/b,
//           valid_out/out_x/out_y (input delayed 2 clocks), blink_phase.
// BLINK_FRAMES: frames per blink half-period, legal range 1..255.
module overlay_mixer #(
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic           clk,
  input  logic           reset,
  overlay_mixer_if.slave pix
);
  localparam int          NUM_LAYERS = 3;
  localparam int          STAGES     = 2;
  localparam logic [7:0]  LAST_FRAME = 8'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [23:0] rgb;
    logic        vpx;
  } layer_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } coord_t;

  layer_t [NUM_LAYERS-1:0] l_in, l_s1;
  coord_t                  c_in, c_s1, c_s2;
  logic   [STAGES:0]       vld_pipe;
  logic   [NUM_LAYERS-1:0] eff;
  logic   [23:0]           sel, rgb_q;
  logic   [7:0]            frame_cnt;
  logic                    phase;
  logic   [NUM_LAYERS-1:0] blink_en_q;
  logic                    fs;

  assign l_in[0] = {pix.l0_r, pix.l0_g, pix.l0_b, pix.l0_valid_px};
  assign l_in[1] = {pix.l1_r, pix.l1_g, pix.l1_b, pix.l1_valid_px};
  assign l_in[2] = {pix.l2_r, pix.l2_g, pix.l2_b, pix.l2_valid_px};
  assign c_in    = {pix.vga_x, pix.vga_y};
  assign vld_pipe[0] = pix.valid;

  // Frame start is judged on the raw inputs so the phase/enable update lands
  // on the same edge that captures pixel (0,0) into stage 1: the whole new
  // frame sees the new phase, the old frame's tail never does.
  assign fs = pix.valid && (pix.vga_x == 11'd0) && (pix.vga_y == 10'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt  <= '0;
      phase      <= 1'b0;
      blink_en_q <= '0;
    end else if (fs) begin
      blink_en_q <= pix.blink_en;
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Stage 1: free-running capture, no stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_s1 <= '0;
      c_s1 <= '0;
    end else begin
      l_s1 <= l_in;
      c_s1 <= c_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // A layer is hidden while its latched blink enable is set during the
  // hidden phase.
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
    assign eff[i] = l_s1[i].vpx && !(blink_en_q[i] && phase);
  end

  // Walk lowest to highest priority so the last hit (layer 0) wins.
  always_comb begin
    sel = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) sel = l_s1[i].rgb;
    end
    if (!vld_pipe[1]) sel = '0;
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q <= '0;
      c_s2  <= '0;
    end else begin
      rgb_q <= sel;
      c_s2  <= c_s1;
    end
  end

  assign pix.r           = rgb_q[23:16];
  assign pix.g           = rgb_q[15:8];
  assign pix.b           = rgb_q[7:0];
  assign pix.valid_out   = vld_pipe[STAGES];
  assign pix.out_x       = c_s2.x;
  assign pix.out_y       = c_s2.y;
  assign pix.blink_phase = phase;
endmodule
